// File: rtl/nearpm_dma_pkg.sv
// Shared constants and state encoding for the near-PM DMA request arbiter.
package nearpm_dma_pkg;

  localparam int DMA_FIELD_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT     = 2'd2,
    ST_COMPLETE = 2'd3
  } dma_state_e;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: the first set request at or after
// (last_grant + 1) mod NUM_REQ wins, wrapping around the vector.
module rr_priority_select #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] last_grant,
  output logic                 valid,
  output logic [IDX_WIDTH-1:0] index
);

  int                   cand;
  logic [IDX_WIDTH-1:0] cand_idx;

  // Walk the ring starting just past the last winner; the first hit sticks.
  always_comb begin
    valid    = 1'b0;
    index    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant) + k) % NUM_REQ;
      cand_idx = IDX_WIDTH'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        index = cand_idx;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/dma_request_arbiter.sv
// Round-robin arbiter that serialises near-PM copy requests onto a single
// DMA driver, one outstanding descriptor at a time.
module dma_request_arbiter
  import nearpm_dma_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = DMA_FIELD_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_SRC,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_DEST,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_LEN,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic [NUM_REQ-1:0]            REQ_DONE,
  output logic                          DMA_START,
  output logic [ADDR_WIDTH-1:0]         DMA_SRC,
  output logic [ADDR_WIDTH-1:0]         DMA_DEST,
  output logic [ADDR_WIDTH-1:0]         DMA_LEN,
  input  logic                          DMA_DONE,
  output logic                          BUSY,
  output logic [$clog2(NUM_REQ)-1:0]    GRANT_ID
);

  localparam int IDX_WIDTH = $clog2(NUM_REQ);

  dma_state_e             state_r, state_next_s;
  logic [IDX_WIDTH-1:0]   last_grant_r, grant_id_r, sel_index_s;
  logic                   sel_valid_s, grant_s;
  logic [ADDR_WIDTH-1:0]  src_r, dest_r, len_r;
  logic [ADDR_WIDTH-1:0]  sel_src_s, sel_dest_s, sel_len_s;
  logic [NUM_REQ-1:0]     sel_onehot_s, grant_onehot_s, ready_r, done_r;
  logic                   start_r, busy_r;

  rr_priority_select #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_select (
    .req        (REQ_VALID),
    .last_grant (last_grant_r),
    .valid      (sel_valid_s),
    .index      (sel_index_s)
  );

  assign sel_src_s      = REQ_SRC [int'(sel_index_s)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_dest_s     = REQ_DEST[int'(sel_index_s)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_len_s      = REQ_LEN [int'(sel_index_s)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_onehot_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_index_s;
  assign grant_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_r;

  // Next-state logic; DMA_DONE only matters while waiting on the driver.
  always_comb begin
    state_next_s = state_r;
    grant_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_valid_s) begin
          state_next_s = ST_ISSUE;
          grant_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (len_r != '0) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_COMPLETE;
        end
      end
      ST_WAIT: begin
        if (DMA_DONE) begin
          state_next_s = ST_COMPLETE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_COMPLETE: state_next_s = ST_IDLE;
      default:     state_next_s = ST_IDLE;
    endcase
  end

  // State, descriptor latch and registered pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= IDX_WIDTH'(NUM_REQ - 1);
      grant_id_r   <= '0;
      src_r        <= '0;
      dest_r       <= '0;
      len_r        <= '0;
      start_r      <= 1'b0;
      ready_r      <= '0;
      done_r       <= '0;
      busy_r       <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      start_r <= grant_s && (sel_len_s != '0);
      ready_r <= grant_s ? sel_onehot_s : '0;
      done_r  <= (state_next_s == ST_COMPLETE) ? grant_onehot_s : '0;
      if (grant_s) begin
        src_r        <= sel_src_s;
        dest_r       <= sel_dest_s;
        len_r        <= sel_len_s;
        last_grant_r <= sel_index_s;
        grant_id_r   <= sel_index_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  assign REQ_READY = ready_r;
  assign REQ_DONE  = done_r;
  assign DMA_START = start_r;
  assign DMA_SRC   = src_r;
  assign DMA_DEST  = dest_r;
  assign DMA_LEN   = len_r;
  assign BUSY      = busy_r;
  assign GRANT_ID  = grant_id_r;

endmodule

// File: tb/tb_dma_request_arbiter.sv
// Directed self-checking bench for dma_request_arbiter (NUM_REQ=4, 32-bit fields).
module tb_dma_request_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_src, req_dest, req_len;
  logic [N-1:0]    req_ready, req_done;
  logic            dma_start, dma_done, busy;
  logic [AW-1:0]   dma_src, dma_dest, dma_len;
  logic [1:0]      grant_id;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  dma_request_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .REQ_VALID (req_valid),
    .REQ_SRC   (req_src),
    .REQ_DEST  (req_dest),
    .REQ_LEN   (req_len),
    .REQ_READY (req_ready),
    .REQ_DONE  (req_done),
    .DMA_START (dma_start),
    .DMA_SRC   (dma_src),
    .DMA_DEST  (dma_dest),
    .DMA_LEN   (dma_len),
    .DMA_DONE  (dma_done),
    .BUSY      (busy),
    .GRANT_ID  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int s, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input logic [AW-1:0] len);
    req_src [s*AW +: AW] = src;
    req_dest[s*AW +: AW] = dst;
    req_len [s*AW +: AW] = len;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_done"},  64'(req_done),  64'd0);
    chk({tag, "_start"}, 64'(dma_start), 64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_gid"},   64'(grant_id),  64'd0);
    chk({tag, "_src"},   64'(dma_src),   64'd0);
    chk({tag, "_dest"},  64'(dma_dest),  64'd0);
    chk({tag, "_len"},   64'(dma_len),   64'd0);
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_src   = '0;
    req_dest  = '0;
    req_len   = '0;
    dma_done  = 1'b0;
    step();
    step();
    chk_reset_outputs("por");
    reset = 1'b1;

    // Single request from slot 2 with a 10-cycle transfer.
    set_slot(2, 32'h1000, 32'h2000, 32'd64);
    req_valid = 4'b0100;
    step();
    chk("single_ready", 64'(req_ready), 64'h4);
    chk("single_start", 64'(dma_start), 64'd1);
    chk("single_src",   64'(dma_src),   64'h1000);
    chk("single_dest",  64'(dma_dest),  64'h2000);
    chk("single_len",   64'(dma_len),   64'd64);
    chk("single_gid",   64'(grant_id),  64'd2);
    chk("single_busy",  64'(busy),      64'd1);
    req_valid = '0;
    step();
    chk("single_wait_start", 64'(dma_start), 64'd0);
    chk("single_wait_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < 8; i++) step();
    chk("single_hold_src", 64'(dma_src), 64'h1000);
    chk("single_hold_done", 64'(req_done), 64'd0);
    dma_done = 1'b1;
    step();
    dma_done = 1'b0;
    chk("single_done", 64'(req_done), 64'h4);
    chk("single_busy_cpl", 64'(busy), 64'd1);
    step();
    chk("single_idle_busy", 64'(busy), 64'd0);
    chk("single_idle_done", 64'(req_done), 64'd0);

    // Zero-length request from slot 1: no DMA_START, completes straight away.
    set_slot(1, 32'h30, 32'h40, 32'd0);
    req_valid = 4'b0010;
    step();
    chk("zero_ready", 64'(req_ready), 64'h2);
    chk("zero_start", 64'(dma_start), 64'd0);
    chk("zero_gid",   64'(grant_id),  64'd1);
    req_valid = '0;
    step();
    chk("zero_done",       64'(req_done),  64'h2);
    chk("zero_start_cpl",  64'(dma_start), 64'd0);
    step();
    chk("zero_idle_busy", 64'(busy), 64'd0);

    // Spurious DMA_DONE in IDLE and coincident with DMA_START.
    dma_done = 1'b1;
    step();
    dma_done = 1'b0;
    chk("spur_idle_busy", 64'(busy),     64'd0);
    chk("spur_idle_done", 64'(req_done), 64'd0);
    set_slot(0, 32'hA0, 32'hB0, 32'd8);
    req_valid = 4'b0001;
    step();
    chk("spur_ready", 64'(req_ready), 64'h1);
    chk("spur_start", 64'(dma_start), 64'd1);
    req_valid = '0;
    dma_done  = 1'b1;
    step();
    dma_done = 1'b0;
    chk("spur_issue_done", 64'(req_done), 64'd0);
    chk("spur_issue_busy", 64'(busy),     64'd1);
    step();
    chk("spur_wait_done", 64'(req_done), 64'd0);
    dma_done = 1'b1;
    step();
    dma_done = 1'b0;
    chk("spur_real_done", 64'(req_done), 64'h1);
    step();

    // Slot 3 withdraws while busy; slot 1 is the only one left to win.
    set_slot(2, 32'hC00, 32'hD00, 32'd4);
    req_valid = 4'b0100;
    step();
    chk("wd_first_ready", 64'(req_ready), 64'h4);
    set_slot(2, 32'hDEAD, 32'hBEEF, 32'd99);
    set_slot(1, 32'h111, 32'h222, 32'd12);
    set_slot(3, 32'h333, 32'h444, 32'd12);
    req_valid = 4'b1010;
    step();
    chk("wd_latched_src", 64'(dma_src),   64'hC00);
    chk("wd_busy_ready",  64'(req_ready), 64'd0);
    req_valid = 4'b0010;
    dma_done  = 1'b1;
    step();
    dma_done = 1'b0;
    chk("wd_first_done", 64'(req_done), 64'h4);
    step();
    chk("wd_idle_ready", 64'(req_ready), 64'd0);
    step();
    chk("wd_ready", 64'(req_ready), 64'h2);
    chk("wd_gid",   64'(grant_id),  64'd1);
    chk("wd_src",   64'(dma_src),   64'h111);
    req_valid = '0;
    step();
    dma_done = 1'b1;
    step();
    dma_done = 1'b0;
    chk("wd_done", 64'(req_done), 64'h2);
    step();

    // Reset asserted in WAIT clears everything immediately.
    set_slot(3, 32'h333, 32'h444, 32'd16);
    req_valid = 4'b1000;
    step();
    chk("rst_pre_ready", 64'(req_ready), 64'h8);
    chk("rst_pre_gid",   64'(grant_id),  64'd3);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst_wait");

    // All four valid from reset release: order 0,1,2,3,0.
    for (int s = 0; s < N; s++) set_slot(s, AW'((s + 1) * 32'h100), AW'(s * 32'h10), 32'd4);
    req_valid = 4'b1111;
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rr%0d_ready", i), 64'(req_ready), 64'(4'b0001 << (i % N)));
      chk($sformatf("rr%0d_gid", i),   64'(grant_id),  64'(i % N));
      chk($sformatf("rr%0d_src", i),   64'(dma_src),   64'(((i % N) + 1) * 32'h100));
      step();
      dma_done = 1'b1;
      step();
      dma_done = 1'b0;
      chk($sformatf("rr%0d_done", i), 64'(req_done), 64'(4'b0001 << (i % N)));
      step();
    end
    req_valid = '0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dma_request_arbiter.md
DMA_REQUEST_ARBITER -- requirements
Module: dma_request_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesting near-PM units (2..8).
REQ-002 Parameter ADDR_WIDTH, default 32, width of SRC/DEST/LEN fields.
REQ-003 Port clk  input  1  single clock; all logic rising-edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port REQ_VALID  input  NUM_REQ  per-requester copy request, level, held until REQ_READY.
REQ-006 Port REQ_SRC, REQ_DEST, REQ_LEN  input  NUM_REQ*ADDR_WIDTH each  packed request fields; slot i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]; LEN in bytes.
REQ-007 Port REQ_READY  output  NUM_REQ  one-cycle accept pulse, one-hot or zero.
REQ-008 Port REQ_DONE  output  NUM_REQ  one-cycle completion pulse, one-hot or zero.
REQ-009 Port DMA_START  output  1  one-cycle start pulse to the DMA driver.
REQ-010 Port DMA_SRC, DMA_DEST, DMA_LEN  output  ADDR_WIDTH each  registered copy descriptor, stable from DMA_START until DMA_DONE.
REQ-011 Port DMA_DONE  input  1  one-cycle completion pulse from the DMA driver.
REQ-012 Port BUSY  output  1  high in every state except IDLE.
REQ-013 Port GRANT_ID  output  clog2(NUM_REQ)  index of the current/last granted requester.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, COMPLETE; encoding binary.
REQ-015 IDLE: if any REQ_VALID, select winner by round-robin, starting search at (last_grant+1) mod NUM_REQ, wrapping; else stay.
REQ-016 Grant at edge after cycle N with REQ_VALID sampled: cycle N+1 state ISSUE, REQ_READY[winner]=1, DMA_* fields latched from winner slot, GRANT_ID=winner, last_grant updated.
REQ-017 ISSUE with DMA_LEN!=0: DMA_START=1 for exactly that cycle; next state WAIT.
REQ-018 ISSUE with DMA_LEN==0: DMA_START stays 0; next state COMPLETE (no bus traffic).
REQ-019 WAIT: stay until DMA_DONE=1; next state COMPLETE; no timeout.
REQ-020 COMPLETE: REQ_DONE[GRANT_ID]=1 for one cycle; next state IDLE; earliest next grant visible two cycles after DMA_DONE.
REQ-021 DMA_DONE outside WAIT (including coincident with DMA_START) is ignored.
REQ-022 REQ_VALID deasserted before grant is a legal withdrawal; no state change for that slot.
REQ-023 REQ_VALID changes while not in IDLE have no effect; latched descriptor never changes until next grant.
REQ-024 At most one outstanding DMA; REQ_READY and REQ_DONE never pulse for two requesters in one cycle.
REQ-025 Requester re-asserting REQ_VALID immediately after its REQ_DONE loses to any other valid requester (fairness).

Reset
REQ-026 reset=0 forces asynchronously: state IDLE, last_grant=NUM_REQ-1 (so slot 0 wins first), GRANT_ID=0, DMA_SRC/DEST/LEN=0, DMA_START=0, REQ_READY=0, REQ_DONE=0, BUSY=0.
REQ-027 Reset mid-transfer abandons the request with no REQ_DONE; driver is reset by the same signal.

Structure
REQ-028 State encoding and DMA descriptor field width constants reside in shared package nearpm_dma_pkg.
REQ-029 Round-robin selection is sub-module rr_priority_select (inputs: request vector, last_grant; outputs: valid, index), purely combinational.

Verification
REQ-030 Single request: slot 2 valid, SRC=0x1000, DEST=0x2000, LEN=64 -> REQ_READY[2] and DMA_START same cycle, DMA_* match, DMA_DONE after 10 cycles -> REQ_DONE[2] next cycle, BUSY low after.
REQ-031 All four valid continuously after reset -> grant order 0,1,2,3,0; each REQ_DONE matches prior grant.
REQ-032 Zero length: slot 1 LEN=0 -> REQ_READY[1], no DMA_START, REQ_DONE[1] two cycles after grant.
REQ-033 Spurious DMA_DONE in IDLE and in ISSUE cycle -> ignored, FSM waits for next DMA_DONE in WAIT.
REQ-034 Reset asserted in WAIT -> all outputs at reset values immediately; after release, slot 0 wins first.
REQ-035 Slot 3 withdraws valid before grant while slot 1 valid -> only slot 1 granted, no REQ_READY[3].
